// File: rtl/rl_coef_lut_bank.sv
`default_nettype none
// ============================================================================
// Module   : rl_coef_lut_bank
// Purpose  : Multi-table force-coefficient lookup for the range-limited LJ
//            pipeline. A float32 r2 is turned into a segment/bin address
//            (exponent selects the segment, top mantissa bits select the bin).
//            That address reads NUM_TABLES coefficient RAMs in parallel, with
//            a fixed 3-cycle latency and one lookup per cycle. A load port
//            lets the host rewrite the tables between evaluation phases.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            r2, r2_valid       - float32 squared distance and request strobe
//            lookup_ready       - lookups are accepted this cycle
//            coef_out           - table k at [k*DATA_WIDTH +: DATA_WIDTH]
//            coef_valid         - coef_out valid
//            out_of_range       - qualifies coef_valid: r2 outside the tables
//            load_req           - level request to enter load mode
//            load_ready         - load mode active, writes accepted
//            load_we, load_table, load_addr, load_data - table write port
// Options  : RL_COEF_LUT_CLAMP_EN - out-of-range requests read the first /
//            last table word instead of returning zero coefficients.
// Revision : 1.0 - initial release
// ============================================================================
module rl_coef_lut_bank #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_TABLES    = 2,
  parameter int TSEL_WIDTH    = 1,
  parameter int SEGMENT_NUM   = 12,
  parameter int SEGMENT_WIDTH = 4,
  parameter int BIN_WIDTH     = 8,
  parameter int ADDR_WIDTH    = 12,
  parameter int DEPTH         = 3072,
  parameter int MIN_EXP       = 124
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [31:0]                      r2,
  input  logic                             r2_valid,
  output logic                             lookup_ready,
  output logic [NUM_TABLES*DATA_WIDTH-1:0] coef_out,
  output logic                             coef_valid,
  output logic                             out_of_range,
  input  logic                             load_req,
  output logic                             load_ready,
  input  logic                             load_we,
  input  logic [TSEL_WIDTH-1:0]            load_table,
  input  logic [ADDR_WIDTH-1:0]            load_addr,
  input  logic [DATA_WIDTH-1:0]            load_data
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  state_e state_q;
  logic   lookup_ready_q;
  logic   load_ready_q;

  // ---------------------------------------------------------------- S0
  logic [7:0]               exp_w;
  logic [SEGMENT_WIDTH-1:0] seg_w;
  logic                     range_lo_w;
  logic                     range_hi_w;
  logic [ADDR_WIDTH-1:0]    addr_raw_w;
  logic [ADDR_WIDTH-1:0]    addr_w;
  logic                     accept_w;
  logic                     unused_ok_w;

  assign exp_w      = r2[30:23];
  // Only the low segment bits matter; out-of-range exponents are flagged below.
  assign seg_w      = SEGMENT_WIDTH'(exp_w - 8'(MIN_EXP));
  assign range_lo_w = r2[31] | ({24'd0, exp_w} < 32'(MIN_EXP));
  assign range_hi_w = ({24'd0, exp_w} >= 32'(MIN_EXP + SEGMENT_NUM));
  assign addr_raw_w = {seg_w, r2[22 -: BIN_WIDTH]};
  assign accept_w   = r2_valid & lookup_ready_q;
  // Low mantissa bits below the bin field do not affect the lookup.
  assign unused_ok_w = ^r2[22-BIN_WIDTH:0];

`ifdef RL_COEF_LUT_CLAMP_EN
  always_comb begin
    addr_w = addr_raw_w;
    if (range_lo_w) begin
      addr_w = '0;
    end else if (range_hi_w) begin
      addr_w = ADDR_WIDTH'(DEPTH - 1);
    end
  end
`else
  // Out-of-range results are zeroed at the output, so the read address is moot.
  assign addr_w = addr_raw_w;
`endif

  logic                  s0_valid_q;
  logic                  s0_oor_q;
  logic [ADDR_WIDTH-1:0] s0_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_oor_q   <= 1'b0;
      s0_addr_q  <= '0;
    end else begin
      s0_valid_q <= accept_w;
      s0_oor_q   <= range_lo_w | range_hi_w;
      s0_addr_q  <= addr_w;
    end
  end

  // ---------------------------------------------------------------- S1 (RAMs)
  logic                             we_w;
  logic [NUM_TABLES*DATA_WIDTH-1:0] rd_w;

  // Writes only in load mode, and only to an existing table and word.
  assign we_w = load_we & load_ready_q
              & ({{(32-TSEL_WIDTH){1'b0}}, load_table} < 32'(NUM_TABLES))
              & ({{(32-ADDR_WIDTH){1'b0}}, load_addr} < 32'(DEPTH));

  for (genvar k = 0; k < NUM_TABLES; k++) begin : g_table
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Table storage is intentionally not reset so contents survive rst.
    always_ff @(posedge clk) begin
      if (we_w && (load_table == TSEL_WIDTH'(k))) begin
        mem_q[load_addr] <= load_data;
      end
      rd_q <= mem_q[s0_addr_q];
    end

    assign rd_w[k*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

  logic s1_valid_q;
  logic s1_oor_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_oor_q   <= 1'b0;
    end else begin
      s1_valid_q <= s0_valid_q;
      s1_oor_q   <= s0_oor_q;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [NUM_TABLES*DATA_WIDTH-1:0] coef_q;
  logic                             coef_valid_q;
  logic                             oor_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      coef_q       <= '0;
      coef_valid_q <= 1'b0;
      oor_q        <= 1'b0;
    end else begin
      coef_valid_q <= s1_valid_q;
      oor_q        <= s1_valid_q & s1_oor_q;
`ifdef RL_COEF_LUT_CLAMP_EN
      coef_q       <= rd_w;
`else
      coef_q       <= s1_oor_q ? '0 : rd_w;
`endif
    end
  end

  // ---------------------------------------------------------------- FSM
  logic pipe_empty_w;
  assign pipe_empty_w = ~(s0_valid_q | s1_valid_q | coef_valid_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      lookup_ready_q <= 1'b1;
      load_ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_req) begin
            state_q        <= ST_DRAIN;
            lookup_ready_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty_w) begin
            if (load_req) begin
              state_q      <= ST_LOAD;
              load_ready_q <= 1'b1;
            end else begin
              // Request withdrawn while draining: skip load mode entirely.
              state_q        <= ST_RUN;
              lookup_ready_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (!load_req) begin
            state_q        <= ST_RUN;
            lookup_ready_q <= 1'b1;
            load_ready_q   <= 1'b0;
          end
        end
        default: begin
          state_q        <= ST_RUN;
          lookup_ready_q <= 1'b1;
          load_ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign lookup_ready = lookup_ready_q;
  assign load_ready   = load_ready_q;
  assign coef_out     = coef_q;
  assign coef_valid   = coef_valid_q;
  assign out_of_range = oor_q;

endmodule
`default_nettype wire
